// File: rtl/bip_control_unit.sv
// Multicycle control unit for the accumulator processor: fetch/decode/exec
// sequencing, opcode decode, program counter, halt flag and cycle counter.
module bip_control_unit #(
    localparam int unsigned AB  = 11,
    localparam int unsigned DB  = 16,
    localparam int unsigned OPB = 5
) (
    input  logic          clk,
    input  logic          reset,
    output logic [AB-1:0] pc_addr,
    input  logic [DB-1:0] instr_in,
    output logic [AB-1:0] operand,
    output logic          wr_ram,
    output logic          rd_ram,
    output logic [1:0]    sel_a,
    output logic          sel_b,
    output logic          alu_op,
    output logic          wr_acc,
    output logic          halted,
    output logic [DB-1:0] cycle_count
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    typedef struct packed {
        logic       wr_ram;
        logic       rd_ram;
        logic [1:0] sel_a;
        logic       sel_b;
        logic       alu_op;
        logic       wr_acc;
    } ctrl_t;

    localparam logic [OPB-1:0] OP_HLT  = OPB'(0);
    localparam logic [OPB-1:0] OP_STO  = OPB'(1);
    localparam logic [OPB-1:0] OP_LD   = OPB'(2);
    localparam logic [OPB-1:0] OP_LDI  = OPB'(3);
    localparam logic [OPB-1:0] OP_ADD  = OPB'(4);
    localparam logic [OPB-1:0] OP_ADDI = OPB'(5);
    localparam logic [OPB-1:0] OP_SUB  = OPB'(6);
    localparam logic [OPB-1:0] OP_SUBI = OPB'(7);

    localparam logic [1:0] SEL_A_RAM = 2'd0;
    localparam logic [1:0] SEL_A_IMM = 2'd1;
    localparam logic [1:0] SEL_A_ALU = 2'd2;

    state_t          state;
    state_t          state_next;
    logic [DB-1:0]   ir;
    logic [AB-1:0]   pc;
    logic [OPB-1:0]  ir_op;
    logic [OPB-1:0]  fetch_op;
    ctrl_t           dec;

    assign ir_op    = ir[DB-1:DB-OPB];
    assign fetch_op = instr_in[DB-1:DB-OPB];
    assign pc_addr  = pc;
    assign operand  = ir[AB-1:0];

    // Decode the word about to enter the IR so controls register alongside it.
    always_comb begin
        dec = '0;
        case (fetch_op)
            OP_STO:  dec.wr_ram = 1'b1;
            OP_LD:   begin dec.rd_ram = 1'b1; dec.sel_a = SEL_A_RAM; dec.wr_acc = 1'b1; end
            OP_LDI:  begin dec.sel_a = SEL_A_IMM; dec.wr_acc = 1'b1; end
            OP_ADD:  begin dec.rd_ram = 1'b1; dec.sel_a = SEL_A_ALU; dec.wr_acc = 1'b1; end
            OP_ADDI: begin dec.sel_b = 1'b1; dec.sel_a = SEL_A_ALU; dec.wr_acc = 1'b1; end
            OP_SUB:  begin dec.rd_ram = 1'b1; dec.alu_op = 1'b1; dec.sel_a = SEL_A_ALU;
                           dec.wr_acc = 1'b1; end
            OP_SUBI: begin dec.sel_b = 1'b1; dec.alu_op = 1'b1; dec.sel_a = SEL_A_ALU;
                           dec.wr_acc = 1'b1; end
            default: dec = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: state_next = S_EXEC;
            S_EXEC:   state_next = (ir_op == OP_HLT) ? S_HALT : S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Strobes are only loaded on the DECODE->EXEC edge, so they live for EXEC alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir          <= '0;
            pc          <= '0;
            halted      <= 1'b0;
            cycle_count <= '0;
            wr_ram      <= 1'b0;
            rd_ram      <= 1'b0;
            wr_acc      <= 1'b0;
            sel_a       <= 2'd0;
            sel_b       <= 1'b0;
            alu_op      <= 1'b0;
        end else begin
            if (state != S_HALT) begin
                cycle_count <= cycle_count + DB'(1);
            end
            wr_ram <= (state == S_DECODE) & dec.wr_ram;
            rd_ram <= (state == S_DECODE) & dec.rd_ram;
            wr_acc <= (state == S_DECODE) & dec.wr_acc;
            if (state == S_DECODE) begin
                ir     <= instr_in;
                sel_a  <= dec.sel_a;
                sel_b  <= dec.sel_b;
                alu_op <= dec.alu_op;
            end
            if (state == S_EXEC) begin
                if (ir_op == OP_HLT) begin
                    halted <= 1'b1;
                end else begin
                    pc <= pc + AB'(1);
                end
            end
        end
    end

endmodule

// File: doc/bip_control_unit.md
# bip_control_unit

Multicycle control unit for the accumulator processor. Fetches 16-bit instructions from a synchronous program ROM, latches them in an instruction register, decodes the 5-bit opcode into datapath controls, and presents the 11-bit operand field to the downstream `Signal_Extension` stage. It also maintains the program counter, a halt flag and a cycle counter that the debug/UART logic reads.

## Interface

- `AB`, 11, operand/PC width; equals the `Signal_Extension` input width.
- `DB`, 16, instruction and data width.
- `OPB`, 5, opcode width; `OPB + AB == DB`.

Ports:

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `pc_addr`  out  AB  program ROM address; equals the PC register.
- `instr_in`  in  DB  ROM read data, valid one cycle after `pc_addr` is presented.
- `operand`  out  AB  `IR[AB-1:0]`; drives `Signal_Extension.Addr` and the data RAM address.
- `wr_ram`  out  1  data RAM write strobe.
- `rd_ram`  out  1  data RAM read enable.
- `sel_a`  out  2  accumulator source: 0 = RAM, 1 = sign-extended operand, 2 = ALU.
- `sel_b`  out  1  ALU B source: 0 = RAM, 1 = sign-extended operand.
- `alu_op`  out  1  0 = add, 1 = subtract.
- `wr_acc`  out  1  accumulator load enable.
- `halted`  out  1  set once HLT has executed.
- `cycle_count`  out  DB  clock cycles since reset, frozen on halt.

## Operation

- State machine has four states: FETCH, DECODE, EXEC and HALT.
  - FETCH → DECODE unconditionally.
  - DECODE → EXEC unconditionally; the IR is loaded from `instr_in` in this state.
  - EXEC → HALT if `IR[DB-1:DB-OPB]` is HLT; otherwise EXEC → FETCH.
  - HALT → HALT. Only `reset` leaves HALT.
- Opcodes and their EXEC-state controls (unlisted controls are 0):
  - 00000 HLT: no controls.
  - 00001 STO: `wr_ram`.
  - 00010 LD: `rd_ram`, `sel_a`=0, `wr_acc`.
  - 00011 LDI: `sel_a`=1, `wr_acc`.
  - 00100 ADD: `rd_ram`, `sel_b`=0, `alu_op`=0, `sel_a`=2, `wr_acc`.
  - 00101 ADDI: `sel_b`=1, `alu_op`=0, `sel_a`=2, `wr_acc`.
  - 00110 SUB: as ADD but `alu_op`=1.
  - 00111 SUBI: as ADDI but `alu_op`=1.
  - 01000–11111: NOP. All controls stay 0 and the PC still increments.
- Qualification by state:
  - Strobes `wr_ram`, `rd_ram` and `wr_acc` are asserted only while the state is EXEC.
  - `sel_a`, `sel_b` and `alu_op` are decoded from the IR in every state, so they are stable during EXEC.
- PC:
  - PC ← PC+1 modulo 2^AB on the EXEC→FETCH transition only.
  - 2^AB−1 wraps to 0 with no flag.
  - PC is not incremented on HLT.
- `cycle_count` increments by 1 every cycle in which the state is not HALT and `reset` is low. It wraps modulo 2^DB.

## Timing

- Reset values: state FETCH, PC 0, IR 0, `operand` 0, every strobe 0, `sel_a`/`sel_b`/`alu_op` 0, `halted` 0, `cycle_count` 0.
- Throughput is 3 cycles per instruction.
- Cycle sequence, with t0 = first cycle after `reset` deasserts:
  - t0 FETCH: `pc_addr`=PC.
  - t1 DECODE: `instr_in` valid; IR loaded at the end of t1.
  - t2 EXEC: controls valid and `operand` valid; PC updates at the end of t2.
- `operand` changes only at the end of DECODE. It is held through EXEC and the following FETCH and DECODE, so the downstream sign extension and RAM address are stable during each strobe.
- `halted` rises at the end of the EXEC cycle of HLT. It is registered and is first high in the cycle the state is HALT.
- `reset` sampled high in any state, including mid-EXEC, returns all registers to their reset values at that edge. A strobe is never asserted in the cycle after `reset` is sampled high.

## Test plan

- Reset, then ROM[0]=LDI 5 (0x1805):
  - t2: `wr_acc`=1, `sel_a`=1, `operand`=0x005.
  - t3: `pc_addr`=1, all strobes 0.
- Program LDI 0x7FF, ADDI 3, STO 0x010, HLT:
  - Per-instruction controls match the opcode list.
  - `wr_ram` is high exactly one cycle, with `operand`=0x010.
  - `halted`=1 at cycle 12.
  - `cycle_count` freezes at 12.
  - `pc_addr` stays 3.
- ROM word 0x4000 (opcode 01000): no strobe during EXEC; the PC advances by 1.
- Force PC to 0x7FF by filling the ROM with NOPs: after 2048 instructions, `pc_addr` wraps to 0x000 and the halt flag stays 0.
- Assert `reset` for one cycle during EXEC of STO:
  - `wr_ram` is 0 from the next cycle.
  - PC=0, state FETCH, `cycle_count`=0.
- From HALT, hold for 100 cycles: outputs are unchanged. Then pulse `reset`: execution restarts at PC 0.
